// File: rtl/attention_pkg.sv
// Shared constants and the saturating Q8.8 extraction helper for attention_core.
package attention_pkg;

    localparam int FRAC_BITS      = 8;
    localparam int ONE_Q          = 256;
    localparam int LOG2E_Q        = 369;
    localparam int EXP_ZERO_SHIFT = 9;
    localparam int ACC_WIDTH      = 40;

    // Drop the extra fraction bits of a Q16.16 sum; any set bit above 23 saturates.
    function automatic logic [15:0] sat_q88(input logic [ACC_WIDTH-1:0] acc);
        logic [ACC_WIDTH-1:0] shifted;
        shifted = acc >> FRAC_BITS;
        if (shifted > ACC_WIDTH'(16'hFFFF)) begin
            return 16'hFFFF;
        end
        return shifted[15:0];
    endfunction

endpackage

// File: rtl/attention_core_softmax_row.sv
// softmax_row: combinational base-2 softmax over one row of TOKEN_NUM Q8.8 scores.
module softmax_row
    import attention_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TOKEN_NUM  = 8
) (
    input  logic [DATA_WIDTH*TOKEN_NUM-1:0] scores,
    output logic [DATA_WIDTH*TOKEN_NUM-1:0] weights
);

    localparam int SUM_W = $clog2(ONE_Q*TOKEN_NUM+1);

    logic [DATA_WIDTH-1:0] row_max;
    logic [16:0]           y_val [TOKEN_NUM];
    logic [8:0]            e_val [TOKEN_NUM];
    logic [SUM_W-1:0]      e_sum;

    always_comb begin
        row_max = '0;
        for (int j = 0; j < TOKEN_NUM; j++) begin
            if (scores[DATA_WIDTH*j +: DATA_WIDTH] > row_max) begin
                row_max = scores[DATA_WIDTH*j +: DATA_WIDTH];
            end
        end
    end

    // exp(-d) as 2^-(d*log2e): integer part is a shift, fraction a linear 1 - f/2.
    always_comb begin
        e_sum = '0;
        for (int j = 0; j < TOKEN_NUM; j++) begin
            y_val[j] = 17'((32'(row_max - scores[DATA_WIDTH*j +: DATA_WIDTH]) * 32'(LOG2E_Q)) >> FRAC_BITS);
            if (y_val[j][16:8] >= 9'(EXP_ZERO_SHIFT)) begin
                e_val[j] = '0;
            end else begin
                e_val[j] = (9'(ONE_Q) - {1'b0, y_val[j][7:1]}) >> y_val[j][16:8];
            end
            e_sum = e_sum + SUM_W'(e_val[j]);
        end
    end

    always_comb begin
        weights = '0;
        for (int j = 0; j < TOKEN_NUM; j++) begin
            weights[DATA_WIDTH*j +: DATA_WIDTH] = DATA_WIDTH'({e_val[j], 8'b0} / 17'(e_sum));
        end
    end

endmodule

// File: rtl/attention_core.sv
// attention_core: 4-register pipelined single-head attention, softmax(Q*K^T)*V in Q8.8.
// Define ATTENTION_SCALE_EN to scale stage-1 scores right by $clog2(TOKEN_DIM)/2 bits.
module attention_core
    import attention_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TOKEN_DIM  = 4,
    parameter int TOKEN_NUM  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q,
    input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K,
    input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] token_out
);

    localparam int BLK_W = DATA_WIDTH*TOKEN_DIM*TOKEN_NUM;
    localparam int MAT_W = DATA_WIDTH*TOKEN_NUM*TOKEN_NUM;
    localparam int ROW_W = DATA_WIDTH*TOKEN_NUM;

`ifdef ATTENTION_SCALE_EN
    localparam int SCORE_SHIFT = $clog2(TOKEN_DIM) / 2;
`else
    localparam int SCORE_SHIFT = 0;
`endif

    logic [BLK_W-1:0] q_r, k_r, v_r, v_d1, v_d2;
    logic [MAT_W-1:0] A_stage_1_to_2, S_stage_2_to_3;
    logic [MAT_W-1:0] a_next, s_next;
    logic [BLK_W-1:0] out_next;

    for (genvar i = 0; i < TOKEN_NUM; i++) begin : g_score_row
        for (genvar j = 0; j < TOKEN_NUM; j++) begin : g_score_col
            logic [ACC_WIDTH-1:0] acc;
            always_comb begin
                acc = '0;
                for (int t = 0; t < TOKEN_DIM; t++) begin
                    acc = acc + ACC_WIDTH'(q_r[DATA_WIDTH*(i*TOKEN_DIM+t) +: DATA_WIDTH])
                              * ACC_WIDTH'(k_r[DATA_WIDTH*(j*TOKEN_DIM+t) +: DATA_WIDTH]);
                end
            end
            assign a_next[DATA_WIDTH*(i*TOKEN_NUM+j) +: DATA_WIDTH] = sat_q88(acc) >> SCORE_SHIFT;
        end
    end

    for (genvar i = 0; i < TOKEN_NUM; i++) begin : g_softmax
        softmax_row #(
            .DATA_WIDTH(DATA_WIDTH),
            .TOKEN_NUM (TOKEN_NUM)
        ) u_softmax_row (
            .scores (A_stage_1_to_2[ROW_W*i +: ROW_W]),
            .weights(s_next[ROW_W*i +: ROW_W])
        );
    end

    for (genvar i = 0; i < TOKEN_NUM; i++) begin : g_out_row
        for (genvar j = 0; j < TOKEN_DIM; j++) begin : g_out_col
            logic [ACC_WIDTH-1:0] acc;
            always_comb begin
                acc = '0;
                for (int t = 0; t < TOKEN_NUM; t++) begin
                    acc = acc + ACC_WIDTH'(S_stage_2_to_3[DATA_WIDTH*(i*TOKEN_NUM+t) +: DATA_WIDTH])
                              * ACC_WIDTH'(v_d2[DATA_WIDTH*(t*TOKEN_DIM+j) +: DATA_WIDTH]);
                end
            end
            assign out_next[DATA_WIDTH*(i*TOKEN_DIM+j) +: DATA_WIDTH] = sat_q88(acc);
        end
    end

    // V travels two extra registers so stage 3 pairs it with the weights of its own block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r            <= '0;
            k_r            <= '0;
            v_r            <= '0;
            v_d1           <= '0;
            v_d2           <= '0;
            A_stage_1_to_2 <= '0;
            S_stage_2_to_3 <= '0;
            token_out      <= '0;
        end else begin
            q_r            <= Q;
            k_r            <= K;
            v_r            <= V;
            v_d1           <= v_r;
            v_d2           <= v_d1;
            A_stage_1_to_2 <= a_next;
            S_stage_2_to_3 <= s_next;
            token_out      <= out_next;
        end
    end

endmodule

// File: tb/tb_attention_core.sv
// Self-checking bench for attention_core: directed table, pipeline/reset sequences, random stream.
module tb_attention_core;

    localparam int W     = 16;
    localparam int D     = 4;
    localparam int N     = 8;
    localparam int BLK_W = W*D*N;
    localparam int MAT_W = W*N*N;
    localparam int NR    = 200;

    typedef logic [BLK_W-1:0] blk_t;
    typedef logic [MAT_W-1:0] mat_t;

    typedef struct {
        string name;
        blk_t  q, k, v, out;
        mat_t  a, s;
        bit    chk_a, chk_s;
    } vec_t;

    logic clk;
    logic rst_n;
    blk_t Q, K, V;
    blk_t token_out;

    int checks = 0;
    int errors = 0;

    vec_t vecs[4];
    mat_t exp_a[NR];
    mat_t exp_s[NR];
    blk_t exp_o[NR];

    attention_core #(
        .DATA_WIDTH(W),
        .TOKEN_DIM (D),
        .TOKEN_NUM (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Q        (Q),
        .K        (K),
        .V        (V),
        .token_out(token_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sat16(input longint x);
        longint t;
        t = x / 256;
        return (t > 65535) ? 65535 : t;
    endfunction

    // Reference: plain integer matrices, straight from the arithmetic definition.
    task automatic ref_model(input blk_t q, input blk_t k, input blk_t v,
                             output mat_t a, output mat_t s, output blk_t o);
        longint sc [N][N];
        longint wt [N][N];
        longint e  [N];
        longint acc, m, d, y, n, f, total;
        a = '0;
        s = '0;
        o = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int t = 0; t < D; t++) begin
                    acc += longint'(q[W*(i*D+t) +: W]) * longint'(k[W*(j*D+t) +: W]);
                end
                sc[i][j] = sat16(acc);
`ifdef ATTENTION_SCALE_EN
                sc[i][j] = sc[i][j] / (2 ** ($clog2(D) / 2));
`endif
                a[W*(i*N+j) +: W] = W'(sc[i][j]);
            end
        end
        for (int i = 0; i < N; i++) begin
            m = 0;
            for (int j = 0; j < N; j++) m = (sc[i][j] > m) ? sc[i][j] : m;
            total = 0;
            for (int j = 0; j < N; j++) begin
                d = m - sc[i][j];
                y = (d * 369) / 256;
                n = y / 256;
                f = y % 256;
                e[j] = (n >= 9) ? 0 : (256 - f / 2) / (2 ** n);
                total += e[j];
            end
            for (int j = 0; j < N; j++) begin
                wt[i][j] = (e[j] * 256) / total;
                s[W*(i*N+j) +: W] = W'(wt[i][j]);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < D; j++) begin
                acc = 0;
                for (int t = 0; t < N; t++) acc += wt[i][t] * longint'(v[W*(t*D+j) +: W]);
                o[W*(i*D+j) +: W] = W'(sat16(acc));
            end
        end
    endtask

    function automatic blk_t rand_blk(input logic [15:0] mask);
        blk_t b;
        for (int e = 0; e < D*N; e++) b[W*e +: W] = 16'($urandom) & mask;
        return b;
    endfunction

    function automatic logic [15:0] rand_mask();
        case ($urandom_range(0, 2))
            0:       return 16'h00FF;
            1:       return 16'h03FF;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input blk_t q, input blk_t k, input blk_t v);
        Q = q;
        K = k;
        V = v;
    endtask

    task automatic check_output(input string name, input mat_t got, input mat_t exp, input int nelem);
        checks++;
        if (got !== exp) begin
            errors++;
            for (int e = 0; e < nelem; e++) begin
                if (got[W*e +: W] !== exp[W*e +: W]) begin
                    $display("[TB] FAIL %s elem %0d got %h expected %h", name, e, got[W*e +: W], exp[W*e +: W]);
                    break;
                end
            end
        end
    endtask

    initial begin
        blk_t bq, bk, bv, bo, rq, rk, rv, ro;
        mat_t ma, ms;
        logic [15:0] mq;

        // Directed table: expected values are the hand-derived constants.
        for (int x = 0; x < 4; x++) begin
            bq = '0; bk = '0; bv = '0; bo = '0; ma = '0; ms = '0;
            for (int e = 0; e < N*N; e++) ms[W*e +: W] = 16'h0020;
            case (x)
                0: begin
                    vecs[x].name = "uniform";
                    for (int e = 0; e < D*N; e++) begin
                        bv[W*e +: W] = 16'h0100;
                        bo[W*e +: W] = 16'h0100;
                    end
                end
                1: begin
                    vecs[x].name = "ramp";
                    for (int e = 0; e < D*N; e++) begin
                        bv[W*e +: W] = 16'((e / D) * 256);
                        bo[W*e +: W] = 16'h0380;
                    end
                end
                2: begin
                    vecs[x].name = "dominant";
                    ms = '0;
                    bk[W*0 +: W] = 16'h0800;
                    for (int i = 0; i < N; i++) begin
                        bq[W*(i*D) +: W]   = 16'h0100;
                        ma[W*(i*N) +: W]   = 16'h0800;
                        ms[W*(i*N) +: W]   = 16'h0100;
                        for (int j = 0; j < D; j++) bo[W*(i*D+j) +: W] = 16'((j + 1) * 256);
                    end
                    for (int j = 0; j < D; j++) bv[W*j +: W] = 16'((j + 1) * 256);
                end
                default: begin
                    vecs[x].name = "saturation";
                    for (int e = 0; e < D*N; e++) begin
                        bq[W*e +: W] = 16'h7F00;
                        bk[W*e +: W] = 16'h7F00;
                        bv[W*e +: W] = 16'h0100;
                        bo[W*e +: W] = 16'h0100;
                    end
                    for (int e = 0; e < N*N; e++) ma[W*e +: W] = 16'hFFFF;
                end
            endcase
`ifdef ATTENTION_SCALE_EN
            if (x == 2) begin
                ref_model(bq, bk, bv, ma, ms, bo);
                for (int i = 0; i < N; i++) ma[W*(i*N) +: W] = 16'h0400;
            end
            if (x == 3) for (int e = 0; e < N*N; e++) ma[W*e +: W] = 16'h7FFF;
`endif
            vecs[x].q = bq; vecs[x].k = bk; vecs[x].v = bv; vecs[x].out = bo;
            vecs[x].a = ma; vecs[x].s = ms;
            vecs[x].chk_a = 1'b1;
            vecs[x].chk_s = 1'b1;
        end

        rst_n = 1'b0;
        apply_stimulus(rand_blk(16'hFFFF), rand_blk(16'hFFFF), rand_blk(16'hFFFF));
        step();
        check_output("reset_out", MAT_W'(token_out), '0, D*N);
        check_output("reset_A", dut.A_stage_1_to_2, '0, N*N);
        check_output("reset_S", dut.S_stage_2_to_3, '0, N*N);
        rst_n = 1'b1;

        for (int x = 0; x < 4; x++) begin
            apply_stimulus(vecs[x].q, vecs[x].k, vecs[x].v);
            repeat (4) step();
            check_output({vecs[x].name, "_out"}, MAT_W'(token_out), MAT_W'(vecs[x].out), D*N);
            if (vecs[x].chk_a) check_output({vecs[x].name, "_A"}, dut.A_stage_1_to_2, vecs[x].a, N*N);
            if (vecs[x].chk_s) check_output({vecs[x].name, "_S"}, dut.S_stage_2_to_3, vecs[x].s, N*N);
        end

        // Three blocks back to back, then hold the last one.
        for (int x = 0; x < 3; x++) begin
            apply_stimulus(vecs[x].q, vecs[x].k, vecs[x].v);
            step();
        end
        for (int x = 0; x < 4; x++) begin
            step();
            check_output("pipe_order", MAT_W'(token_out), MAT_W'(vecs[(x < 3) ? x : 2].out), D*N);
        end

        // Randomised stream against the reference model.
        for (int c = 0; c < NR + 3; c++) begin
            if (c < NR) begin
                mq = rand_mask();
                rq = rand_blk(mq);
                rk = rand_blk(mq);
                rv = rand_blk(16'hFFFF);
                apply_stimulus(rq, rk, rv);
                ref_model(rq, rk, rv, exp_a[c], exp_s[c], exp_o[c]);
            end
            step();
            if (c >= 1 && c - 1 < NR) check_output("rand_A", dut.A_stage_1_to_2, exp_a[c-1], N*N);
            if (c >= 2 && c - 2 < NR) check_output("rand_S", dut.S_stage_2_to_3, exp_s[c-2], N*N);
            if (c >= 3) check_output("rand_out", MAT_W'(token_out), MAT_W'(exp_o[c-3]), D*N);
        end

        // Reset in the middle of a stream flushes everything in flight.
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(rand_blk(16'h03FF), rand_blk(16'h03FF), rand_blk(16'hFFFF));
            step();
        end
        rst_n = 1'b0;
        apply_stimulus(rand_blk(16'h03FF), rand_blk(16'h03FF), rand_blk(16'hFFFF));
        step();
        check_output("midrst_out", MAT_W'(token_out), '0, D*N);
        check_output("midrst_A", dut.A_stage_1_to_2, '0, N*N);
        check_output("midrst_S", dut.S_stage_2_to_3, '0, N*N);
        rst_n = 1'b1;
        rq = rand_blk(16'h03FF);
        rk = rand_blk(16'h03FF);
        rv = rand_blk(16'hFFFF);
        apply_stimulus(rq, rk, rv);
        ref_model(rq, rk, rv, ma, ms, ro);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_output((c < 4) ? "midrst_zero" : "midrst_first", MAT_W'(token_out),
                         (c < 4) ? '0 : MAT_W'(ro), D*N);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
